// File: rtl/sector_pkg.sv
// Shared encodings for the sector region-growing sequencer and its helpers.
package sector_pkg;

    // Array-wide phase driven onto every cell's state[1:0] input.
    typedef enum logic [1:0] {
        STOP_ST = 2'b00,
        COST_ST = 2'b01,
        ROOT_ST = 2'b10,
        SAVE_ST = 2'b11
    } phase_e;

    // Neighborhood shape selected for a whole pass.
    typedef enum logic {
        C8L16 = 1'b0,
        C16L8 = 1'b1
    } nbh_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GROW  = 3'd2,
        S_COST  = 3'd3,
        S_ROOT  = 3'd4,
        S_SAVE  = 3'd5,
        S_DONE  = 3'd6
    } ctrl_state_e;

    // Larger of two integers, used to size the shared phase timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/grow_quiet_det.sv
// Detects that region growth has settled: counts consecutive quiet cycles
// (no cell transmitting) and flags the cycle in which the run reaches
// QUIET_CYCLES. Held at zero whenever clr is high.
module grow_quiet_det #(
    parameter int QUIET_CYCLES = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic any_transmit,
    output logic settled
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);

    logic [QW-1:0] quiet_cnt_q;
    logic [QW-1:0] quiet_cnt_d;

    // Saturating quiet counter; any transmit restarts the run.
    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        if (clr || any_transmit) begin
            quiet_cnt_d = '0;
        end else if (quiet_cnt_q != QUIET_MAX) begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
        // Settled in the very cycle the quiet run completes, so the
        // controller can leave GROW on this edge.
        settled = !clr && (quiet_cnt_d == QUIET_MAX);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_cnt_q <= '0;
        end else begin
            quiet_cnt_q <= quiet_cnt_d;
        end
    end

endmodule

// File: rtl/sector_grow_ctrl.sv
// Sequencer for the sector region-growing cell array: clears the cells,
// runs growth until the array goes quiet (or times out), then steps the
// array through COST, ROOT and SAVE and reports completion.
module sector_grow_ctrl
    import sector_pkg::*;
#(
    parameter int QUIET_CYCLES = 9,
    parameter int COST_CYCLES  = 4,
    parameter int ROOT_CYCLES  = 2,
    parameter int TMO_W        = 10,
    parameter int STOP_TMO     = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             nbh_sel,
    input  logic             any_transmit,
    input  logic             save_ack,
    output logic             run,
    output logic             neighborhood,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [TMO_W-1:0] grow_cycles
);

    localparam int PH_W = $clog2(max2(COST_CYCLES, ROOT_CYCLES) + 1);
    localparam logic [PH_W-1:0]  COST_LOAD = PH_W'(COST_CYCLES - 1);
    localparam logic [PH_W-1:0]  ROOT_LOAD = PH_W'(ROOT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(STOP_TMO);

    ctrl_state_e      st_q, st_d;
    logic [PH_W-1:0]  ph_tmr_q, ph_tmr_d;
    nbh_e             nbh_q, nbh_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] gc_q, gc_d;
    logic             run_q, run_d;
    phase_e           phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             settled;

    // Quiet counter only runs while the array is growing.
    grow_quiet_det #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (st_q != S_GROW),
        .any_transmit(any_transmit),
        .settled     (settled)
    );

    // Next-state logic; outputs are derived from the next state so the
    // registered outputs always line up with the registered FSM state.
    always_comb begin
        st_d     = st_q;
        ph_tmr_d = ph_tmr_q;
        nbh_d    = nbh_q;
        err_d    = err_q;
        gc_d     = gc_q;
        if (abort) begin
            st_d = S_IDLE;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_d  = S_CLEAR;
                        nbh_d = nbh_e'(nbh_sel);
                        err_d = 1'b0;
                        gc_d  = '0;
                    end
                end
                S_CLEAR: st_d = S_GROW;
                S_GROW: begin
                    gc_d = gc_q + TMO_W'(1);
                    // Settling takes priority over a coincident timeout.
                    if (settled) begin
                        st_d     = S_COST;
                        ph_tmr_d = COST_LOAD;
                    end else if (gc_d == TMO_MAX) begin
                        st_d  = S_DONE;
                        err_d = 1'b1;
                    end
                end
                S_COST: begin
                    if (ph_tmr_q == '0) begin
                        st_d     = S_ROOT;
                        ph_tmr_d = ROOT_LOAD;
                    end else begin
                        ph_tmr_d = ph_tmr_q - PH_W'(1);
                    end
                end
                S_ROOT: begin
                    if (ph_tmr_q == '0) begin
                        st_d = S_SAVE;
                    end else begin
                        ph_tmr_d = ph_tmr_q - PH_W'(1);
                    end
                end
                S_SAVE:  if (save_ack) st_d = S_DONE;
                S_DONE:  st_d = S_IDLE;
                default: st_d = S_IDLE;
            endcase
        end

        run_d  = (st_d == S_GROW) || (st_d == S_COST) ||
                 (st_d == S_ROOT) || (st_d == S_SAVE);
        busy_d = (st_d != S_IDLE);
        done_d = (st_d == S_DONE);
        case (st_d)
            S_COST:  phase_d = COST_ST;
            S_ROOT:  phase_d = ROOT_ST;
            S_SAVE:  phase_d = SAVE_ST;
            default: phase_d = STOP_ST;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            ph_tmr_q <= '0;
            nbh_q    <= C8L16;
            err_q    <= 1'b0;
            gc_q     <= '0;
            run_q    <= 1'b0;
            phase_q  <= STOP_ST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            ph_tmr_q <= ph_tmr_d;
            nbh_q    <= nbh_d;
            err_q    <= err_d;
            gc_q     <= gc_d;
            run_q    <= run_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign run          = run_q;
    assign neighborhood = nbh_q;
    assign state        = phase_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign grow_cycles  = gc_q;

endmodule

// File: tb/tb_sector_grow_ctrl.sv
// Bench for sector_grow_ctrl. Output vector layout used throughout:
// {run, state[1:0], busy, done, neighborhood, err}.
module tb_sector_grow_ctrl;
    import sector_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       nbh_sel = 1'b0;
    logic       any_transmit = 1'b0;
    logic       save_ack = 1'b0;
    logic       run;
    logic       neighborhood;
    logic [1:0] state;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] grow_cycles;

    sector_grow_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .nbh_sel     (nbh_sel),
        .any_transmit(any_transmit),
        .save_ack    (save_ack),
        .run         (run),
        .neighborhood(neighborhood),
        .state       (state),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .grow_cycles (grow_cycles)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        int         n;
        logic       start;
        logic       nbh_sel;
        logic       any_tx;
        logic       save_ack;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] outs();
        return {run, state, busy, done, neighborhood, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Push the expected outputs for this edge, clock it, pop and compare.
    task automatic step_exp(input string name, input logic [6:0] e);
        logic [6:0] want;
        exp_q.push_back(e);
        tick();
        want = exp_q.pop_front();
        check(name, 16'(outs()), 16'(want));
    endtask

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got_done;
        logic saw_cost;
        logic [6:0] e;
        logic [1:0] st;

        // Reset.
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outs", 16'(outs()), 16'h0);
        check("reset_gc", 16'(grow_cycles), 16'h0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 16'(outs()), 16'h0);

        // Main pass: transmit pulses on GROW cycles 2-5, SAVE held 20 cycles.
        tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0_00_1_0_1_0}); // CLEAR
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_00_1_0_1_0}); // enter GROW
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_00_1_0_1_0}); // grow 1
        tbl.push_back('{4,  1'b0, 1'b0, 1'b1, 1'b0, 7'b1_00_1_0_1_0}); // grow 2-5
        tbl.push_back('{8,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_00_1_0_1_0}); // grow 6-13
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_01_1_0_1_0}); // grow 14 -> COST
        tbl.push_back('{3,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_01_1_0_1_0}); // COST
        tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_10_1_0_1_0}); // ROOT
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1_11_1_0_1_0}); // enter SAVE
        tbl.push_back('{20, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1_11_1_0_1_0}); // SAVE wait
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b1, 7'b0_00_1_1_1_0}); // DONE
        tbl.push_back('{3,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0_00_0_0_1_0}); // IDLE
        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                start        = tbl[r].start;
                nbh_sel      = tbl[r].nbh_sel;
                any_transmit = tbl[r].any_tx;
                save_ack     = tbl[r].save_ack;
                step_exp($sformatf("main_row%0d_cyc%0d", r, k), tbl[r].exp);
            end
        end
        check("main_grow_cycles", 16'(grow_cycles), 16'd14);

        // Timeout: transmit stuck high.
        start = 1'b1;
        nbh_sel = 1'b0;
        any_transmit = 1'b1;
        tick();
        start = 1'b0;
        check("tmo_gc_cleared", 16'(grow_cycles), 16'd0);
        got_done = 1'b0;
        saw_cost = 1'b0;
        for (int i = 0; i < 1100 && !got_done; i++) begin
            tick();
            if (state == COST_ST) saw_cost = 1'b1;
            if (done) got_done = 1'b1;
        end
        check("tmo_done_seen", 16'(got_done), 16'd1);
        check("tmo_no_cost", 16'(saw_cost), 16'd0);
        check("tmo_err", 16'(err), 16'd1);
        check("tmo_gc", 16'(grow_cycles), 16'd1023);
        any_transmit = 1'b0;
        step_exp("tmo_idle", 7'b0_00_0_0_0_1);

        // Abort and start together in IDLE: abort wins, err and count kept.
        abort = 1'b1;
        start = 1'b1;
        step_exp("abort_start_idle", 7'b0_00_0_0_0_1);
        check("abort_keeps_gc", 16'(grow_cycles), 16'd1023);
        abort = 1'b0;

        // Quiet run completes on the same cycle as the timeout: COST wins.
        start = 1'b1;
        any_transmit = 1'b1;
        step_exp("qw_clear", 7'b0_00_1_0_0_0);
        check("qw_gc_cleared", 16'(grow_cycles), 16'd0);
        start = 1'b0;
        step_exp("qw_grow_entry", 7'b1_00_1_0_0_0);
        for (int c = 1; c <= 1022; c++) begin
            any_transmit = (c <= 1014);
            tick();
        end
        check("qw_still_grow", 16'(outs()), 16'(7'b1_00_1_0_0_0));
        any_transmit = 1'b0;
        step_exp("qw_cost", 7'b1_01_1_0_0_0);
        check("qw_gc", 16'(grow_cycles), 16'd1023);
        step_exp("qw_cost_hold", 7'b1_01_1_0_0_0);

        // Abort during COST: straight to IDLE, no done pulse.
        abort = 1'b1;
        step_exp("abort_cost", 7'b0_00_0_0_0_0);
        abort = 1'b0;

        // start held through an entire pass; save_ack held too, so it is
        // ignored until SAVE. A new pass only starts after DONE.
        start = 1'b1;
        save_ack = 1'b1;
        any_transmit = 1'b0;
        nbh_sel = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n >= 11 && n <= 14) st = 2'b01;
            else if (n >= 15 && n <= 16) st = 2'b10;
            else if (n == 17) st = 2'b11;
            else st = 2'b00;
            e = {(n >= 2 && n <= 17), st, (n != 19), (n == 18), 1'b0, 1'b0};
            step_exp($sformatf("held_start_%0d", n), e);
        end
        start = 1'b0;
        save_ack = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset in the middle of GROW.
        start = 1'b1;
        nbh_sel = 1'b1;
        any_transmit = $urandom_range(0, 1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            any_transmit = $urandom_range(0, 1);
            tick();
        end
        check("pre_reset_grow", 16'(outs()), 16'(7'b1_00_1_0_1_0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 16'(outs()), 16'h0);
        check("async_reset_gc", 16'(grow_cycles), 16'h0);
        #2;
        rst_n = 1'b1;
        any_transmit = 1'b0;
        step_exp("post_reset_idle", 7'b0_00_0_0_0_0);
        start = 1'b1;
        nbh_sel = 1'b1;
        step_exp("post_reset_start", 7'b0_00_1_0_1_0);
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
